// File: rtl/axis_pkg.sv
// axis_pkg: shared types and elaboration-time helpers for axis_pkt_fifo
//   drop_state_t : ingress drop FSM states
//   keep_w       : tkeep width for a given tdata width
//   depth_ok     : DEPTH must be a power of two and at least 4
//   mode_ok      : dropping on overflow only makes sense for store-and-forward
package axis_pkg;
  typedef enum logic {ACCEPT, DROP} drop_state_t;
  function automatic int keep_w(int w);
    return w / 8;
  endfunction
  function automatic bit depth_ok(int d);
    return d >= 4 && (d & (d - 1)) == 0;
  endfunction
  function automatic bit mode_ok(int store_fwd, int drop_on_full);
    return drop_on_full == 0 || store_fwd != 0;
  endfunction
endpackage

// File: rtl/axis_pkt_fifo_ram.sv
// axis_pkt_fifo_ram: simple dual-port storage, synchronous write, asynchronous read
//   clk          : write clock
//   we/waddr/wdata : write port
//   raddr/rdata  : combinational read port
module axis_pkt_fifo_ram #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: AXI-Stream packet FIFO, cut-through or store-and-forward with optional packet drop
//   clk, rst_n       : clock, asynchronous active-low reset
//   s_axis_*         : ingress stream
//   m_axis_*         : egress stream (first-word fall-through)
//   prog_full        : registered, occupancy >= PROG_FULL_TH
//   pkt_cnt          : committed packets currently stored
//   drop_cnt         : saturating count of dropped packets
module axis_pkt_fifo
  import axis_pkg::*;
#(
  parameter int TDATA_WIDTH  = 512,
  parameter int DEPTH        = 16,
  parameter int STORE_FWD    = 1,
  parameter int DROP_ON_FULL = 1,
  parameter int PROG_FULL_TH = 11
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [TDATA_WIDTH-1:0]           s_axis_tdata,
  input  logic [keep_w(TDATA_WIDTH)-1:0]   s_axis_tkeep,
  input  logic                             s_axis_tlast,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  output logic [TDATA_WIDTH-1:0]           m_axis_tdata,
  output logic [keep_w(TDATA_WIDTH)-1:0]   m_axis_tkeep,
  output logic                             m_axis_tlast,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             prog_full,
  output logic [$clog2(DEPTH):0]           pkt_cnt,
  output logic [31:0]                      drop_cnt
);
  localparam int KW = keep_w(TDATA_WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = TDATA_WIDTH + KW + 1;
  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("axis_pkt_fifo: DEPTH must be a power of two >= 4");
  end
  if (!mode_ok(STORE_FWD, DROP_ON_FULL)) begin : g_bad_mode
    $error("axis_pkt_fifo: DROP_ON_FULL requires STORE_FWD");
  end
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d, occ_d;
  logic [31:0]   drop_cnt_q, drop_cnt_d;
  drop_state_t   state_q, state_d;
  logic          ready_q, prog_full_q, prog_full_d;
  logic          full, in_acc, wr_en, drop, rd_en;
  logic [EW-1:0] rd_ent;
  // full comes from registered pointers only, so a same-cycle read never makes room
  assign full          = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
  assign s_axis_tready = ready_q && (DROP_ON_FULL != 0 || !full);
  assign m_axis_tvalid = rd_ptr_q != commit_ptr_q;
  // gate the unreset array so every egress output reads zero while nothing is valid
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = m_axis_tvalid ? rd_ent : '0;
  assign in_acc    = s_axis_tvalid && s_axis_tready;
  assign rd_en     = m_axis_tvalid && m_axis_tready;
  assign prog_full = prog_full_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  always_comb begin
    drop         = DROP_ON_FULL != 0 && in_acc && state_q == ACCEPT && full;
    wr_en        = in_acc && (DROP_ON_FULL == 0 || (state_q == ACCEPT && !full));
    state_d      = drop && !s_axis_tlast ? DROP :
                   state_q == DROP && in_acc && s_axis_tlast ? ACCEPT : state_q;
    // a drop rewinds the write pointer over the partial packet already stored
    wr_ptr_d     = wr_en ? wr_ptr_q + PW'(1) : drop ? commit_ptr_q : wr_ptr_q;
    commit_ptr_d = STORE_FWD == 0 || (wr_en && s_axis_tlast) ? wr_ptr_d : commit_ptr_q;
    rd_ptr_d     = rd_ptr_q + PW'(rd_en);
    pkt_cnt_d    = pkt_cnt_q + PW'(wr_en && s_axis_tlast) - PW'(rd_en && m_axis_tlast);
    drop_cnt_d   = drop && drop_cnt_q != '1 ? drop_cnt_q + 32'd1 : drop_cnt_q;
    occ_d        = wr_ptr_d - rd_ptr_d;
    prog_full_d  = occ_d >= PW'(PROG_FULL_TH);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      pkt_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      state_q      <= ACCEPT;
      ready_q      <= 1'b0;
      prog_full_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_cnt_q    <= pkt_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      state_q      <= state_d;
      ready_q      <= 1'b1;
      prog_full_q  <= prog_full_d;
    end
  axis_pkt_fifo_ram #(.W(EW), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata ({s_axis_tdata, s_axis_tkeep, s_axis_tlast}),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_ent)
  );
endmodule
